// File: rtl/t_ff.sv
// Bank of WIDTH independent T flip-flops with complementary outputs.
// Optional saturating toggle-event counter enabled by defining T_FF_TOGGLE_COUNT_EN.

module t_ff_lane #(
  parameter logic RESET_BIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q
);
  // Initialiser gives a known start value even if rst is never asserted.
  logic q_q = RESET_BIT;
  logic q_d;

  always_comb q_d = q_q ^ t;

  always_ff @(posedge clk) begin
    if (rst) q_q <= RESET_BIT;
    else     q_q <= q_d;
  end

  assign q = q_q;
endmodule

module t_ff #(
  parameter int unsigned          WIDTH       = 1,
  parameter logic [WIDTH-1:0]     RESET_VALUE = '0,
  parameter int unsigned          CNT_WIDTH   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     t,
  output logic [WIDTH-1:0]     q,
  output logic [WIDTH-1:0]     qbar
`ifdef T_FF_TOGGLE_COUNT_EN
  ,
  output logic [CNT_WIDTH-1:0] toggle_count
`endif
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    t_ff_lane #(.RESET_BIT(RESET_VALUE[i])) u_lane (
      .clk (clk),
      .rst (rst),
      .t   (t[i]),
      .q   (q[i])
    );
  end

  assign qbar = ~q;

`ifdef T_FF_TOGGLE_COUNT_EN
  logic [CNT_WIDTH-1:0] cnt_q = '0;
  logic [CNT_WIDTH-1:0] cnt_d;

  // Counts edges where any lane toggles; sticks at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if ((|t) && (cnt_q != {CNT_WIDTH{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign toggle_count = cnt_q;
`else
  logic [CNT_WIDTH-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_t_ff.sv
// Scoreboard bench for t_ff: WIDTH=1 bank (also counter build, CNT_WIDTH=2) and WIDTH=4 bank.
module tb_t_ff;
  logic       clk = 1'b0;
  logic       rst1, rst4;
  logic [0:0] t1;
  logic [3:0] t4;
  logic [0:0] q1, qb1;
  logic [3:0] q4, qb4;
`ifdef T_FF_TOGGLE_COUNT_EN
  logic [1:0] cnt1;
`endif

  typedef struct packed {
    logic       e1;
    logic [3:0] e4;
    logic [1:0] ec;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  t_ff #(.WIDTH(1), .RESET_VALUE(1'b0), .CNT_WIDTH(2)) u1 (
    .clk  (clk),
    .rst  (rst1),
    .t    (t1),
    .q    (q1),
    .qbar (qb1)
`ifdef T_FF_TOGGLE_COUNT_EN
    ,
    .toggle_count (cnt1)
`endif
  );

  t_ff #(.WIDTH(4), .RESET_VALUE(4'b1010)) u4 (
    .clk  (clk),
    .rst  (rst4),
    .t    (t4),
    .q    (q4),
    .qbar (qb4)
`ifdef T_FF_TOGGLE_COUNT_EN
    ,
    .toggle_count ()
`endif
  );

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
    end
  endtask

  // Drive one edge's inputs and enqueue what both banks must show after that edge.
  task automatic step(input logic r1_v, input logic t1_v, input logic e1_v,
                      input logic r4_v, input logic [3:0] t4_v, input logic [3:0] e4_v,
                      input logic [1:0] ec_v);
    exp_t e;
    rst1 = r1_v; t1 = t1_v; rst4 = r4_v; t4 = t4_v;
    e.e1 = e1_v; e.e4 = e4_v; e.ec = ec_v;
    exp_q.push_back(e);
  endtask

  // Monitor: every edge produces a new registered output; compare against queue head.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("q1",    {3'b000, q1},  {3'b000, e.e1});
        chk("qbar1", {3'b000, qb1}, {3'b000, ~e.e1});
        chk("q4",    q4,  e.e4);
        chk("qbar4", qb4, ~e.e4);
`ifdef T_FF_TOGGLE_COUNT_EN
        chk("cnt", {2'b00, cnt1}, {2'b00, e.ec});
`endif
      end
    end
  end

  initial begin
    // edge 5: WIDTH=1 no reset, t=0; WIDTH=4 reset wins over t=1111
    step(0, 0, 0,   1, 4'b1111, 4'b1010, 2'd0);
    #1;
    chk("init_q1",    {3'b000, q1},  4'b0000);
    chk("init_qbar1", {3'b000, qb1}, 4'b0001);
    chk("init_q4",    q4, 4'b1010);
`ifdef T_FF_TOGGLE_COUNT_EN
    chk("init_cnt", {2'b00, cnt1}, 4'd0);
`endif
    @(negedge clk); step(0, 1, 1,   0, 4'b0110, 4'b1100, 2'd1); // 15
    @(negedge clk); step(0, 1, 0,   0, 4'b0000, 4'b1100, 2'd2); // 25
    @(negedge clk); step(0, 1, 1,   0, 4'b1111, 4'b0011, 2'd3); // 35
    @(negedge clk); step(0, 1, 0,   0, 4'b0001, 4'b0010, 2'd3); // 45 saturate
    @(negedge clk); step(0, 1, 1,   1, 4'b0101, 4'b1010, 2'd3); // 55
    @(negedge clk); step(0, 0, 1,   0, 4'b0000, 4'b1010, 2'd3); // 65 hold
    @(negedge clk); step(0, 0, 1,   0, 4'b0000, 4'b1010, 2'd3); // 75 hold
    @(negedge clk); step(0, 1, 0,   0, 4'b1000, 4'b0010, 2'd3); // 85
    @(negedge clk); step(0, 1, 1,   0, 4'b0000, 4'b0010, 2'd3); // 95
    @(negedge clk); step(0, 1, 0,   0, 4'b0000, 4'b0010, 2'd3); // 105
    @(negedge clk); step(0, 1, 1,   0, 4'b0000, 4'b0010, 2'd3); // 115 q=1 before reset
    @(negedge clk); step(1, 1, 0,   0, 4'b0000, 4'b0010, 2'd0); // 125 reset beats toggle
    @(negedge clk); step(0, 1, 1,   0, 4'b0000, 4'b0010, 2'd1); // 135 resume
    @(negedge clk); step(0, 0, 1,   0, 4'b0000, 4'b0010, 2'd1); // 145
    @(negedge clk);
    t1 = 1'b0; t4 = 4'b0000;
    @(posedge clk);
    #2;
    chk("queue_drained", exp_q.size() == 0 ? 4'd0 : 4'd1, 4'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5000;
    $display("FAIL timeout: simulation did not complete, expected finish before 5000 ns");
    $fatal(1);
  end
endmodule
